// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: NOP encoding, fetch-control states
// and the default reset PC.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t FETCH = 2'd0;
  localparam fetch_state_t WAIT  = 2'd1;
  localparam fetch_state_t HOLD  = 2'd2;

endpackage

// File: rtl/if_id_reg.sv
// Generic pipeline register with flush (to all zeros), load and hold; flush has
// priority over load. Reusable for any stage boundary.
module if_id_reg #(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         flush,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q <= '0;
    else if (flush)
      q <= '0;
    else if (load)
      q <= d;
  end

endmodule

// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage: PC, req/ready fetch control with a one-entry skid
// buffer for freeze, branch redirect with drop of in-flight data, and IF/ID.
module if_stage_fetch
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] if_id_pc,
  output logic [DATA_W-1:0] if_id_instr,
  output logic              if_id_valid
);

  localparam int REG_W = ADDR_W + DATA_W + 1;

  fetch_state_t      state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic [ADDR_W-1:0] wait_addr, wait_addr_n;
  logic              discard, discard_n;
  logic              started;
  logic              skid_valid, skid_valid_n;
  logic [ADDR_W-1:0] skid_pc, skid_pc_n;
  logic [DATA_W-1:0] skid_instr, skid_instr_n;
  logic              reg_load, reg_flush;
  logic [REG_W-1:0]  reg_d, reg_q;
  logic [ADDR_W-1:0] next_seq;

  // The outstanding address is kept separately so a redirect can move pc
  // while the uncancellable access is still presented to memory.
  assign imem_req  = started && (state != HOLD);
  assign imem_addr = (state == WAIT) ? wait_addr : pc;
  assign next_seq  = imem_addr + ADDR_W'(4);

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    wait_addr_n  = wait_addr;
    discard_n    = discard;
    skid_valid_n = skid_valid;
    skid_pc_n    = skid_pc;
    skid_instr_n = skid_instr;
    reg_load     = 1'b0;
    reg_flush    = 1'b0;
    reg_d        = {next_seq, imem_rdata, 1'b1};

    if (!started) begin
      state_n = FETCH;
    end else if (branch_taken) begin
      reg_flush    = 1'b1;
      pc_n         = branch_addr;
      skid_valid_n = 1'b0;
      if (imem_req && !imem_ready) begin
        discard_n = 1'b1;
        state_n   = WAIT;
        if (state == FETCH)
          wait_addr_n = pc;
      end else begin
        discard_n = 1'b0;
        state_n   = FETCH;
      end
    end else begin
      case (state)
        FETCH, WAIT: begin
          if (imem_ready) begin
            if (discard) begin
              discard_n = 1'b0;
              state_n   = FETCH;
            end else if (!freeze) begin
              reg_load = 1'b1;
              pc_n     = next_seq;
              state_n  = FETCH;
            end else begin
              skid_valid_n = 1'b1;
              skid_pc_n    = next_seq;
              skid_instr_n = imem_rdata;
              pc_n         = next_seq;
              state_n      = HOLD;
            end
          end else begin
            if (state == FETCH)
              wait_addr_n = pc;
            state_n = WAIT;
            if (!freeze)
              reg_flush = 1'b1;
          end
        end
        HOLD: begin
          if (!freeze) begin
            reg_load     = 1'b1;
            reg_d        = {skid_pc, skid_instr, 1'b1};
            skid_valid_n = 1'b0;
            state_n      = FETCH;
          end
        end
        default: state_n = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      wait_addr  <= RESET_PC;
      discard    <= 1'b0;
      started    <= 1'b0;
      skid_valid <= 1'b0;
      skid_pc    <= '0;
      skid_instr <= DATA_W'(NOP_INSTR);
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      wait_addr  <= wait_addr_n;
      discard    <= discard_n;
      started    <= 1'b1;
      skid_valid <= skid_valid_n;
      skid_pc    <= skid_pc_n;
      skid_instr <= skid_instr_n;
    end
  end

  if_id_reg #(.W(REG_W)) u_if_id (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (reg_load),
    .flush (reg_flush),
    .d     (reg_d),
    .q     (reg_q)
  );

  assign {if_id_pc, if_id_instr, if_id_valid} = reg_q;

endmodule

// File: tb/tb_if_stage_fetch.sv
// Directed, table-driven bench for if_stage_fetch with a behavioural
// instruction memory whose ready strobe is scripted per cycle.
module tb_if_stage_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready = 1'b0;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        ready;
    logic        frz;
    logic        br;
    logic [31:0] baddr;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t vecs[29];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  assign imem_rdata = instr_of(imem_addr);

  if_stage_fetch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ready   (imem_ready),
    .if_id_pc     (if_id_pc),
    .if_id_instr  (if_id_instr),
    .if_id_valid  (if_id_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic f, input logic b,
                              input logic [31:0] ba, input logic er,
                              input logic [31:0] ea, input logic ev,
                              input logic [31:0] ep);
    vec_t v;
    v.ready = r; v.frz = f; v.br = b; v.baddr = ba;
    v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep;
    v.exp_instr = ev ? instr_of(ep - 32'd4) : 32'h0;
    return v;
  endfunction

  task automatic apply_stimulus(input vec_t v, input int idx);
    @(negedge clk);
    imem_ready   = v.ready;
    freeze       = v.frz;
    branch_taken = v.br;
    branch_addr  = v.baddr;
    #1;
    check_output($sformatf("v%0d imem_req", idx), {31'b0, imem_req}, {31'b0, v.exp_req});
    if (v.exp_req)
      check_output($sformatf("v%0d imem_addr", idx), imem_addr, v.exp_addr);
    @(posedge clk);
    #1;
    check_output($sformatf("v%0d if_id_valid", idx), {31'b0, if_id_valid}, {31'b0, v.exp_valid});
    check_output($sformatf("v%0d if_id_pc", idx), if_id_pc, v.exp_pc);
    check_output($sformatf("v%0d if_id_instr", idx), if_id_instr, v.exp_instr);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, " imem_req"}, {31'b0, imem_req}, 32'h0);
    check_output({tag, " if_id_valid"}, {31'b0, if_id_valid}, 32'h0);
    check_output({tag, " if_id_pc"}, if_id_pc, 32'h0);
    check_output({tag, " if_id_instr"}, if_id_instr, 32'h0);
  endtask

  initial begin
    // ready freeze branch baddr | req addr | valid if_id_pc (instr derived)
    vecs[0]  = mk(1, 0, 0, 0,            1, 32'h0,        1, 32'h4);
    vecs[1]  = mk(1, 0, 0, 0,            1, 32'h4,        1, 32'h8);
    vecs[2]  = mk(0, 0, 0, 0,            1, 32'h8,        0, 32'h0);
    vecs[3]  = mk(0, 0, 0, 0,            1, 32'h8,        0, 32'h0);
    vecs[4]  = mk(1, 0, 0, 0,            1, 32'h8,        1, 32'hC);
    vecs[5]  = mk(1, 1, 0, 0,            1, 32'hC,        1, 32'hC);
    vecs[6]  = mk(1, 1, 0, 0,            0, 32'h0,        1, 32'hC);
    vecs[7]  = mk(1, 0, 0, 0,            0, 32'h0,        1, 32'h10);
    vecs[8]  = mk(1, 0, 0, 0,            1, 32'h10,       1, 32'h14);
    vecs[9]  = mk(0, 0, 0, 0,            1, 32'h14,       0, 32'h0);
    vecs[10] = mk(0, 0, 1, 32'h40,       1, 32'h14,       0, 32'h0);
    vecs[11] = mk(0, 0, 0, 0,            1, 32'h14,       0, 32'h0);
    vecs[12] = mk(1, 0, 0, 0,            1, 32'h14,       0, 32'h0);
    vecs[13] = mk(1, 0, 0, 0,            1, 32'h40,       1, 32'h44);
    vecs[14] = mk(1, 1, 1, 32'h80,       1, 32'h44,       0, 32'h0);
    vecs[15] = mk(1, 0, 0, 0,            1, 32'h80,       1, 32'h84);
    vecs[16] = mk(0, 1, 0, 0,            1, 32'h84,       1, 32'h84);
    vecs[17] = mk(1, 0, 0, 0,            1, 32'h84,       1, 32'h88);
    vecs[18] = mk(1, 1, 0, 0,            1, 32'h88,       1, 32'h88);
    vecs[19] = mk(1, 1, 1, 32'h100,      0, 32'h0,        0, 32'h0);
    vecs[20] = mk(1, 0, 0, 0,            1, 32'h100,      1, 32'h104);
    vecs[21] = mk(1, 0, 1, 32'hFFFFFFFC, 1, 32'h104,      0, 32'h0);
    vecs[22] = mk(1, 0, 0, 0,            1, 32'hFFFFFFFC, 1, 32'h0);
    vecs[23] = mk(1, 0, 0, 0,            1, 32'h0,        1, 32'h4);
    vecs[24] = mk(0, 0, 0, 0,            1, 32'h4,        0, 32'h0);
    vecs[25] = mk(0, 0, 1, 32'h200,      1, 32'h4,        0, 32'h0);
    vecs[26] = mk(0, 0, 1, 32'h300,      1, 32'h4,        0, 32'h0);
    vecs[27] = mk(1, 0, 0, 0,            1, 32'h4,        0, 32'h0);
    vecs[28] = mk(1, 0, 0, 0,            1, 32'h300,      1, 32'h304);
    // The wrapped fetch at 0xFFFFFFFC carries pc+4 = 0, so fix its instr.
    vecs[22].exp_instr = instr_of(32'hFFFFFFFC);

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_output("start imem_req", {31'b0, imem_req}, 32'h1);
    check_output("start imem_addr", imem_addr, 32'h0);
    check_output("start if_id_valid", {31'b0, if_id_valid}, 32'h0);

    for (int i = 0; i < 29; i++)
      apply_stimulus(vecs[i], i);

    // Reset while an access is outstanding and marked for discard.
    @(negedge clk);
    imem_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    branch_taken = 1'b1;
    branch_addr  = 32'h400;
    @(posedge clk);
    @(negedge clk);
    branch_taken = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midwait reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_output("restart imem_req", {31'b0, imem_req}, 32'h1);
    check_output("restart imem_addr", imem_addr, 32'h0);
    apply_stimulus(mk(1, 0, 0, 0, 1, 32'h0, 1, 32'h4), 100);
    apply_stimulus(mk(1, 0, 0, 0, 1, 32'h4, 1, 32'h8), 101);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
